ebpc_word_serializer: RTL and testbench
=======================================

// Module: ebpc_word_serializer
// PURPOSE
//  Upstream feeder for the EBPC encoder. Accepts wide memory beats of LANES x DATA_W and serializes them into DATA_W words.
//  Emits a single-word data/last/vld/rdy stream that connects straight to the encoder's data_i/last_i/vld_i/rdy_o.
//  A programmed word count defines each frame; last_o is generated on the final word and unused lanes of the final beat are dropped.
// PARAMETERS
//  DATA_W   ebpc_pkg::DATA_W (8)  width of one serialized word
//  LANES    4                     words per wide input beat (>=2)
//  LEN_W    24                    width of frame length (in words)
// PORTS
//  clk_i         in   1              clock, single domain
//  rst_i         in   1              asynchronous, active-high reset
//  cfg_len_i     in   LEN_W          frame length in DATA_W words, sampled on cfg_start_i
//  cfg_start_i   in   1              one-cycle pulse that starts a frame
//  busy_o        out  1              frame in progress
//  wide_data_i   in   LANES*DATA_W   input beat; lane k = bits [k*DATA_W +: DATA_W]
//  wide_vld_i    in   1              input beat valid
//  wide_rdy_o    out  1              input beat ready
//  data_o        out  DATA_W         serialized word
//  last_o        out  1              final word of frame
//  vld_o         out  1              output valid
//  rdy_i         in   1              output ready
//  frames_o      out  32             completed-frame count (EBPC_SER_PERF_CNT_EN only)
//  stall_cnt_o   out  32             cycles with vld_o & ~rdy_i (EBPC_SER_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset: state IDLE; busy_o, wide_rdy_o, vld_o, last_o = 0; data_o = 0; all counters = 0.
//  - Handshake: a transfer occurs when vld & rdy are high at a clock edge.
//    - vld_o/data_o/last_o stay stable until accepted; they never depend combinationally on rdy_i.
//    - wide_rdy_o may depend combinationally on rdy_i.
//  - FSM states:
//    - IDLE: cfg_start_i with cfg_len_i != 0 latches rem = cfg_len_i, lane = 0, and moves to RUN.
//    - IDLE: cfg_start_i with cfg_len_i = 0 is ignored and the block stays in IDLE.
//    - RUN: beat buffer (LANES words plus a full flag) is serialized lane 0 first.
//      - wide_rdy_o = busy & rem_beats_pending & (~full | (lane==LANES-1 & rdy_i & rem!=1)).
//      - Result: back-to-back beats sustain 1 word/cycle with no bubble.
//    - RUN: on each output transfer, rem decrements and lane increments.
//      - At lane==LANES-1 the buffer is refilled if a beat is presented, otherwise marked empty.
//    - RUN: last_o = (rem==1). When the last_o word transfers, the state returns to IDLE and busy_o falls the next cycle.
//  - Latency: a beat accepted at edge N presents lane 0 on vld_o after edge N (1 cycle).
//  - Final beat: the block accepts exactly ceil(cfg_len/LANES) beats.
//    - Lanes past the remaining count are discarded.
//    - wide_rdy_o stays low after the final beat until the next start, so the next frame's data is never consumed.
//  - cfg_start_i while busy_o = 1 is ignored; the frame in flight is unaffected.
//  - Output stall (rdy_i = 0): all state holds, and no new beat is accepted while the buffer is full and not draining.
//  - Length of exactly 1: the first beat yields one word with last_o = 1; lanes 1..LANES-1 are dropped.
//  - rem counter: LEN_W wide; a count of 2^LEN_W-1 must not wrap; the beat counter is derived as rem > words left in buffer.
//  - Reset mid-frame: everything returns to reset values at once, and a partially consumed beat is lost.
// CONFIGURATION
//  - EBPC_SER_PERF_CNT_EN defined:
//    - frames_o increments on every last_o transfer.
//    - stall_cnt_o increments each cycle with vld_o & ~rdy_i.
//    - Both counters saturate at 2^32-1 and clear only on rst_i.
//  - EBPC_SER_PERF_CNT_EN undefined: frames_o and stall_cnt_o are tied to 0 and no counter flops are inferred.
// STRUCTURE
//  - ebpc_pkg:
//    - ser_state_e typedef {IDLE, RUN}
//    - localparam SER_LANES_DEFAULT = 4
//    - reuse of the existing DATA_W
//  - Single module, no sub-modules; the beat buffer and lane mux are inline.
//  - LANES must be a power of two so that the lane index is $clog2(LANES) bits; enforced with an elaboration-time assertion.
// TESTING
//  - Drive both handshakes with hs_drv_pkg HandshakeDrv and compare the output against .expresp files.
//  - Scenarios:
//    1. len=8, LANES=4, beats 0x03020100 and 0x07060504 back-to-back, rdy_i=1
//       -> words 00..07 on 8 consecutive cycles, last_o only with 07, busy_o low 1 cycle after.
//    2. len=5 with three beats offered
//       -> 5 words 00..04 with last on 04; wide_rdy_o low after the 2nd beat, 3rd beat not consumed.
//    3. len=1
//       -> one word = lane 0 with last_o = 1; other lanes dropped.
//    4. len=0 start, then start during busy
//       -> no activity for len=0; second start ignored and the frame completes with its original length.
//    5. Random rdy_i/wide_vld_i waits (0..3 cycles), len=1000
//       -> 1000 in-order words, exactly one last.
//       -> With the macro defined, frames_o = 1 and stall_cnt_o = count of stalled cycles.
//    6. Assert rst_i mid-frame after 3 words
//       -> vld_o = 0 immediately; a new start with len=4 produces a clean frame from the next beat.

Source files
------------

// File: rtl/ebpc_pkg.sv
// Shared EBPC types and constants: word width, serializer lane default and serializer FSM states.
package ebpc_pkg;

   localparam int DATA_W            = 8;
   localparam int SER_LANES_DEFAULT = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ser_state_e;

endpackage

// File: rtl/ebpc_word_serializer_if.sv
// Frame config, wide input beat stream and serialized word stream of the EBPC word serializer.
// Handshakes: a beat/word moves on a clock edge where its vld and rdy are both high;
// vld/data/last are held until accepted and never depend on the receiver's rdy.
interface ebpc_word_serializer_if
   import ebpc_pkg::*;
#(
   parameter int DATA_W = ebpc_pkg::DATA_W,
   parameter int LANES  = ebpc_pkg::SER_LANES_DEFAULT,
   parameter int LEN_W  = 24
) ();

   logic [LEN_W-1:0]        cfg_len_i;
   logic                    cfg_start_i;
   logic                    busy_o;
   logic [LANES*DATA_W-1:0] wide_data_i;
   logic                    wide_vld_i;
   logic                    wide_rdy_o;
   logic [DATA_W-1:0]       data_o;
   logic                    last_o;
   logic                    vld_o;
   logic                    rdy_i;
   logic [31:0]             frames_o;
   logic [31:0]             stall_cnt_o;
   ser_state_e              dbg_state_o;

   modport master (
      input  cfg_len_i, cfg_start_i, wide_data_i, wide_vld_i, rdy_i,
      output busy_o, wide_rdy_o, data_o, last_o, vld_o, frames_o, stall_cnt_o, dbg_state_o
   );

   modport slave (
      output cfg_len_i, cfg_start_i, wide_data_i, wide_vld_i, rdy_i,
      input  busy_o, wide_rdy_o, data_o, last_o, vld_o, frames_o, stall_cnt_o, dbg_state_o
   );

endinterface

// File: rtl/ebpc_word_serializer.sv
// Serializes LANES x DATA_W beats into a framed DATA_W word stream with last on the final word.
// Optional EBPC_SER_PERF_CNT_EN adds saturating completed-frame and output-stall counters.
module ebpc_word_serializer #(
   parameter int DATA_W = ebpc_pkg::DATA_W,
   parameter int LANES  = ebpc_pkg::SER_LANES_DEFAULT,
   parameter int LEN_W  = 24
) (
   input logic                    clk_i,
   input logic                    rst_i,
   ebpc_word_serializer_if.master bus
);
   import ebpc_pkg::*;

   localparam int LW = $clog2(LANES);
   localparam int CW = LEN_W + 1;

   if ((LANES < 2) || ((LANES & (LANES - 1)) != 0)) begin : g_lanes_chk
      $error("LANES must be a power of two and at least 2");
   end

   ser_state_e        state_q, state_d;
   logic [LEN_W-1:0]  rem_q;
   logic [LW-1:0]     lane_q;
   logic [DATA_W-1:0] beat_q [LANES];
   logic              full_q;

   logic [CW-1:0] words_left;
   logic          beats_pending, last_lane, last_word, start_ok;
   logic          out_xfer, in_xfer, wide_rdy;

   // Remaining beats exist exactly when rem exceeds what the buffer still holds.
   assign words_left    = full_q ? (CW'(LANES) - CW'(lane_q)) : '0;
   assign beats_pending = {1'b0, rem_q} > words_left;
   assign last_lane     = (lane_q == LW'(LANES - 1));
   assign last_word     = full_q && (rem_q == LEN_W'(1));
   assign start_ok      = bus.cfg_start_i && (bus.cfg_len_i != '0);
   assign wide_rdy      = (state_q == RUN) && beats_pending &&
                          (!full_q || (last_lane && bus.rdy_i && (rem_q != LEN_W'(1))));
   assign out_xfer      = full_q && bus.rdy_i;
   assign in_xfer       = bus.wide_vld_i && wide_rdy;

   assign bus.busy_o      = (state_q == RUN);
   assign bus.wide_rdy_o  = wide_rdy;
   assign bus.vld_o       = full_q;
   assign bus.data_o      = beat_q[lane_q];
   assign bus.last_o      = last_word;
   assign bus.dbg_state_o = state_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = RUN;
         RUN:     if (out_xfer && last_word) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rem_q  <= '0;
         lane_q <= '0;
         full_q <= 1'b0;
         for (int k = 0; k < LANES; k++) beat_q[k] <= '0;
      end else if (state_q == IDLE) begin
         if (start_ok) begin
            rem_q  <= bus.cfg_len_i;
            lane_q <= '0;
            full_q <= 1'b0;
         end
      end else begin
         if (out_xfer) begin
            rem_q  <= rem_q - LEN_W'(1);
            lane_q <= lane_q + LW'(1);
            // Final word drops any lanes left in the beat.
            if (last_word || (last_lane && !in_xfer)) full_q <= 1'b0;
         end
         if (in_xfer) begin
            for (int k = 0; k < LANES; k++) beat_q[k] <= bus.wide_data_i[k*DATA_W +: DATA_W];
            full_q <= 1'b1;
            lane_q <= '0;
         end
      end
   end

`ifdef EBPC_SER_PERF_CNT_EN
   logic [31:0] frames_q, stall_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         frames_q <= '0;
         stall_q  <= '0;
      end else begin
         if (out_xfer && last_word && (frames_q != '1)) frames_q <= frames_q + 32'd1;
         if (full_q && !bus.rdy_i && (stall_q != '1))   stall_q  <= stall_q + 32'd1;
      end
   end

   assign bus.frames_o    = frames_q;
   assign bus.stall_cnt_o = stall_q;
`else
   assign bus.frames_o    = '0;
   assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ebpc_word_serializer.sv
// Directed bench for ebpc_word_serializer: frame-level word model, per-cycle output compare, literal pins.
module tb_ebpc_word_serializer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   ebpc_word_serializer_if #(.DATA_W(8), .LANES(4), .LEN_W(24)) bus ();

   ebpc_word_serializer #(.DATA_W(8), .LANES(4), .LEN_W(24)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [8:0] exp_q[$];
   logic [7:0] got_q[$];
   int         xfer_cyc_q[$];
   int         beat_cyc_q[$];
   int         beats_taken = 0;
   int         words_seen  = 0;
   int         frames_model = 0;
   int         stall_model  = 0;
   logic       after_last = 1'b0;
   logic       rdy_rand   = 1'b0;
   logic       rdy_fixed  = 1'b1;
   logic       acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] mk_beat(input int first);
      return {8'(first + 3), 8'(first + 2), 8'(first + 1), 8'(first)};
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      bus.rdy_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
   end

   // Compare process: every shown word must be the head of the expected stream.
   always @(negedge clk) begin
      if (rst) begin
         frames_model = 0;
         stall_model  = 0;
         after_last   = 1'b0;
      end else begin
         if (after_last) begin
            check("busy_after_last", bus.busy_o, 1'b0);
            after_last = 1'b0;
         end
         if (bus.wide_vld_i && bus.wide_rdy_o) begin
            beats_taken++;
            beat_cyc_q.push_back(cyc);
         end
         if (bus.vld_o) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_word: got %0h, want no word", {bus.last_o, bus.data_o});
            end else begin
               check("word", {bus.last_o, bus.data_o}, exp_q[0]);
               if (bus.rdy_i) void'(exp_q.pop_front());
            end
            if (bus.rdy_i) begin
               words_seen++;
               got_q.push_back(bus.data_o);
               xfer_cyc_q.push_back(cyc);
               if (bus.last_o) begin
                  frames_model++;
                  after_last = 1'b1;
               end
            end else begin
               stall_model++;
            end
         end
      end
   end

   task automatic pulse_start(input int len);
      bus.cfg_start_i = 1'b1;
      bus.cfg_len_i   = 24'(len);
      @(posedge clk); #1;
      bus.cfg_start_i = 1'b0;
   endtask

   // Model: a frame of len words is the pattern first, first+1, ... with last on the final one.
   task automatic start_frame(input int len, input int first);
      got_q.delete();
      xfer_cyc_q.delete();
      beat_cyc_q.delete();
      beats_taken = 0;
      words_seen  = 0;
      for (int w = 0; w < len; w++) exp_q.push_back({(w == len - 1), 8'(first + w)});
      pulse_start(len);
   endtask

   task automatic send_beat(input logic [31:0] d, input int gap, input int budget, output logic accepted);
      accepted = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.wide_vld_i  = 1'b1;
      bus.wide_data_i = d;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.wide_rdy_o) begin
            accepted = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (accepted) begin @(posedge clk); #1; end
      bus.wide_vld_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input int beats_req);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!bus.busy_o) begin
            done = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      check("frame_done_in_time", done, 1'b1);
      check("words_left_in_model", exp_q.size(), 0);
      check("beats_taken", beats_taken, beats_req);
   endtask

   initial begin
      bus.cfg_start_i = 1'b0;
      bus.cfg_len_i   = '0;
      bus.wide_vld_i  = 1'b0;
      bus.wide_data_i = '0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_wide_rdy", bus.wide_rdy_o, 1'b0);
      check("rst_vld", bus.vld_o, 1'b0);
      check("rst_last", bus.last_o, 1'b0);
      check("rst_data", bus.data_o, 8'h00);
      check("rst_frames", bus.frames_o, 32'd0);
      check("rst_stall", bus.stall_cnt_o, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: len=8, two back-to-back beats, rdy=1
      start_frame(8, 8'h00);
      send_beat(32'h03020100, 0, 20, acc);
      check("s1_beat0_acc", acc, 1'b1);
      send_beat(32'h07060504, 0, 20, acc);
      check("s1_beat1_acc", acc, 1'b1);
      wait_idle(40, 2);
      check("s1_word_count", got_q.size(), 8);
      check("s1_first_word", got_q[0], 8'h00);
      check("s1_final_word", got_q[7], 8'h07);
      check("s1_latency", xfer_cyc_q[0] - beat_cyc_q[0], 1);
      check("s1_no_bubble", xfer_cyc_q[7] - xfer_cyc_q[0], 7);

      // 2: len=5, third beat must be refused
      start_frame(5, 8'h20);
      send_beat(mk_beat(8'h20), 0, 20, acc);
      send_beat(mk_beat(8'h24), 0, 20, acc);
      check("s2_beat1_acc", acc, 1'b1);
      send_beat(mk_beat(8'h28), 0, 10, acc);
      check("s2_beat2_refused", acc, 1'b0);
      wait_idle(40, 2);
      check("s2_final_word", got_q[4], 8'h24);

      // 3: len=1, only lane 0 with last
      start_frame(1, 8'h40);
      send_beat(32'h43424140, 1, 20, acc);
      wait_idle(40, 1);
      check("s3_word_count", got_q.size(), 1);
      check("s3_word", got_q[0], 8'h40);

      // 4: len=0 ignored; start while busy ignored
      start_frame(0, 0);
      @(negedge clk);
      check("s4_len0_idle", bus.busy_o, 1'b0);
      @(posedge clk); #1;
      send_beat(mk_beat(8'h50), 0, 5, acc);
      check("s4_len0_beat_refused", acc, 1'b0);
      start_frame(4, 8'h60);
      pulse_start(8);
      send_beat(mk_beat(8'h60), 0, 20, acc);
      send_beat(mk_beat(8'h64), 0, 8, acc);
      check("s4_extra_beat_refused", acc, 1'b0);
      wait_idle(40, 1);
      check("s4_word_count", got_q.size(), 4);

      // 5: len=1000 with random waits on both sides
      rdy_rand = 1'b1;
      start_frame(1000, 8'h10);
      for (int b = 0; b < 250; b++) begin
         send_beat(mk_beat(8'h10 + 4 * b), $urandom_range(0, 3), 200, acc);
         if (!acc) begin
            check("s5_beat_acc", acc, 1'b1);
            break;
         end
      end
      wait_idle(5000, 250);
      rdy_rand = 1'b0;
      check("s5_word_count", got_q.size(), 1000);
`ifdef EBPC_SER_PERF_CNT_EN
      check("s5_frames", bus.frames_o, 32'(frames_model));
      check("s5_stalls", bus.stall_cnt_o, 32'(stall_model));
`else
      check("s5_frames_tied", bus.frames_o, 32'd0);
      check("s5_stalls_tied", bus.stall_cnt_o, 32'd0);
`endif

      // 6: reset mid-frame after 3 words, then a clean len=4 frame
      start_frame(8, 8'h70);
      send_beat(mk_beat(8'h70), 0, 20, acc);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (words_seen >= 3) break;
      end
      @(posedge clk); #1;
      check("s6_words_before_rst", words_seen, 3);
      rst = 1'b1;
      #1;
      check("s6_rst_vld", bus.vld_o, 1'b0);
      check("s6_rst_busy", bus.busy_o, 1'b0);
      check("s6_rst_data", bus.data_o, 8'h00);
      check("s6_rst_wide_rdy", bus.wide_rdy_o, 1'b0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      start_frame(4, 8'h80);
      send_beat(mk_beat(8'h80), 0, 20, acc);
      wait_idle(40, 1);
      check("s6_word_count", got_q.size(), 4);
      check("s6_first_word", got_q[0], 8'h80);
      check("s6_final_word", got_q[3], 8'h83);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach the end in time");
      $fatal(1, "watchdog expired");
   end

endmodule
